// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: state, opcode, func3 and datapath-select encodings for the multicycle controller.
// JALR items exist only when MC_CTRL_JALR_EN is defined.
package mc_ctrl_pkg;
    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADR   = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_EXEC_I    = 4'd7,
        S_ALU_WB    = 4'd8,
        S_BRANCH    = 4'd9,
        S_JAL       = 4'd10,
`ifdef MC_CTRL_JALR_EN
        S_JALR      = 4'd11,
`endif
        S_LUI       = 4'd12
    } state_t;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
`ifdef MC_CTRL_JALR_EN
    localparam logic [6:0] OP_JALR = 7'b1100111;
`endif
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_BLT = 3'b100;
    localparam logic [2:0] F3_BGE = 3'b101;

    localparam logic [1:0] A_PC    = 2'b00;
    localparam logic [1:0] A_OLDPC = 2'b01;
    localparam logic [1:0] A_RS1   = 2'b10;

    localparam logic [1:0] B_RS2  = 2'b00;
    localparam logic [1:0] B_IMM  = 2'b01;
    localparam logic [1:0] B_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;
    localparam logic [1:0] RES_IMM    = 2'b11;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_RTYPE = 2'b10;
    localparam logic [1:0] ALU_ITYPE = 2'b11;
endpackage

// File: rtl/multicycle_controller_if.sv
// mc_ctrl_if: instruction/flag inputs and datapath control outputs of the multicycle controller.
interface mc_ctrl_if;
    logic [6:0] opcode;
    logic [2:0] func3;
    logic       zero;
    logic       lt;
    logic       mem_ready;
    logic       pc_write;
    logic       adr_src;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [2:0] imm_src;
    logic [1:0] result_src;
    logic [3:0] state_o;

    modport master (
        input  opcode, func3, zero, lt, mem_ready,
        output pc_write, adr_src, mem_read, mem_write, ir_write, reg_write,
        output alu_src_a, alu_src_b, alu_op, imm_src, result_src, state_o
    );
    modport slave (
        output opcode, func3, zero, lt, mem_ready,
        input  pc_write, adr_src, mem_read, mem_write, ir_write, reg_write,
        input  alu_src_a, alu_src_b, alu_op, imm_src, result_src, state_o
    );
endinterface

// File: rtl/multicycle_controller_branch_cond.sv
// branch_cond: decides whether a conditional branch is taken from func3 and the ALU flags.
module branch_cond
    import mc_ctrl_pkg::*;
(
    input  logic [2:0] i_func3,
    input  logic       i_zero,
    input  logic       i_lt,
    output logic       o_taken
);
    assign o_taken = (i_func3 == F3_BEQ) ? i_zero :
                     (i_func3 == F3_BNE) ? !i_zero :
                     (i_func3 == F3_BLT) ? i_lt :
                     (i_func3 == F3_BGE) ? !i_lt : 1'b0;
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: fetch/decode/execute/memory/writeback sequencer driving all datapath controls.
// Define MC_CTRL_JALR_EN to build the JALR state; otherwise opcode 1100111 is treated as unknown.
module multicycle_controller
    import mc_ctrl_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    mc_ctrl_if.master bus
);
    state_t     r_state, w_next;
    logic       r_run;
    logic       w_en, w_taken;
    logic       w_pc_write, w_adr_src, w_mem_read, w_mem_write, w_ir_write, w_reg_write;
    logic [1:0] w_a, w_b, w_alu_op, w_res;
    logic [2:0] w_imm;

    branch_cond u_branch_cond (
        .i_func3 (bus.func3),
        .i_zero  (bus.zero),
        .i_lt    (bus.lt),
        .o_taken (w_taken)
    );

    // r_run holds outputs quiet until rst_n has been sampled high once
    always_ff @(posedge clk) begin
        r_run   <= rst_n;
        r_state <= rst_n ? w_next : S_FETCH;
    end

    always_comb begin
        w_next      = r_state;
        w_pc_write  = 1'b0;
        w_adr_src   = 1'b0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_ir_write  = 1'b0;
        w_reg_write = 1'b0;
        w_a         = A_PC;
        w_b         = B_RS2;
        w_alu_op    = ALU_ADD;
        w_imm       = IMM_I;
        w_res       = RES_ALUOUT;
        case (r_state)
            S_FETCH: begin
                w_mem_read = 1'b1;
                w_b        = B_FOUR;
                w_res      = RES_ALU;
                w_ir_write = bus.mem_ready;
                w_pc_write = bus.mem_ready;
                w_next     = bus.mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                w_a   = A_OLDPC;
                w_b   = B_IMM;
                w_imm = (bus.opcode == OP_JAL) ? IMM_J : IMM_B;
                case (bus.opcode)
                    OP_R:         w_next = S_EXEC_R;
                    OP_I:         w_next = S_EXEC_I;
                    OP_LW, OP_SW: w_next = S_MEM_ADR;
                    OP_B:         w_next = S_BRANCH;
                    OP_JAL:       w_next = S_JAL;
`ifdef MC_CTRL_JALR_EN
                    OP_JALR:      w_next = S_JALR;
`endif
                    OP_LUI:       w_next = S_LUI;
                    default:      w_next = S_FETCH;
                endcase
            end
            S_MEM_ADR: begin
                w_a    = A_RS1;
                w_b    = B_IMM;
                w_imm  = (bus.opcode == OP_SW) ? IMM_S : IMM_I;
                w_next = (bus.opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                w_mem_read = 1'b1;
                w_adr_src  = 1'b1;
                w_next     = bus.mem_ready ? S_MEM_WB : S_MEM_READ;
            end
            S_MEM_WB: begin
                w_res       = RES_DATA;
                w_reg_write = 1'b1;
                w_next      = S_FETCH;
            end
            S_MEM_WRITE: begin
                w_mem_write = 1'b1;
                w_adr_src   = 1'b1;
                w_next      = bus.mem_ready ? S_FETCH : S_MEM_WRITE;
            end
            S_EXEC_R: begin
                w_a      = A_RS1;
                w_alu_op = ALU_RTYPE;
                w_next   = S_ALU_WB;
            end
            S_EXEC_I: begin
                w_a      = A_RS1;
                w_b      = B_IMM;
                w_alu_op = ALU_ITYPE;
                w_next   = S_ALU_WB;
            end
            S_ALU_WB: begin
                w_reg_write = 1'b1;
                w_next      = S_FETCH;
            end
            S_BRANCH: begin
                w_a        = A_RS1;
                w_alu_op   = ALU_SUB;
                w_pc_write = w_taken;
                w_next     = S_FETCH;
            end
            S_JAL: begin
                w_a        = A_OLDPC;
                w_b        = B_FOUR;
                w_pc_write = 1'b1;
                w_next     = S_ALU_WB;
            end
`ifdef MC_CTRL_JALR_EN
            S_JALR: begin
                w_a    = A_RS1;
                w_b    = B_IMM;
                w_next = S_JAL;
            end
`endif
            S_LUI: begin
                w_imm       = IMM_U;
                w_res       = RES_IMM;
                w_reg_write = 1'b1;
                w_next      = S_FETCH;
            end
            default: w_next = S_FETCH;
        endcase
    end

    // reset gates every control combinationally so in-flight requests drop immediately
    assign w_en           = rst_n & r_run;
    assign bus.pc_write   = w_en & w_pc_write;
    assign bus.adr_src    = w_en & w_adr_src;
    assign bus.mem_read   = w_en & w_mem_read;
    assign bus.mem_write  = w_en & w_mem_write;
    assign bus.ir_write   = w_en & w_ir_write;
    assign bus.reg_write  = w_en & w_reg_write;
    assign bus.alu_src_a  = w_en ? w_a : 2'b00;
    assign bus.alu_src_b  = w_en ? w_b : 2'b00;
    assign bus.alu_op     = w_en ? w_alu_op : 2'b00;
    assign bus.imm_src    = w_en ? w_imm : 3'b000;
    assign bus.result_src = w_en ? w_res : 2'b00;
    assign bus.state_o    = r_state;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed per-scenario checks of the multicycle controller sequencing.
module tb_multicycle_controller;
    import mc_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    mc_ctrl_if bus();

    multicycle_controller dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bit seen_wb = 1'b0;
        rst_n = 1'b1;
        bus.mem_ready = 1'b0;
        #4;
        n_tests++; if (bus.mem_read !== 1'b0) begin n_fail++; $display("FAIL rst_early_fetch got %b exp 0", bus.mem_read); end
        tick();
        bus.opcode = OP_LW;
        bus.mem_ready = 1'b1;
        #4;
        n_tests++; if (bus.state_o !== S_FETCH || bus.mem_read !== 1'b1) begin n_fail++; $display("FAIL rst_first_fetch got state %0d rd %b exp 0/1", bus.state_o, bus.mem_read); end
        tick();
        tick();
        tick();
        bus.mem_ready = 1'b0;
        #4;
        n_tests++; if (bus.state_o !== S_MEM_READ || bus.mem_read !== 1'b1 || bus.adr_src !== 1'b1) begin n_fail++; $display("FAIL rst_lw_memread got state %0d rd %b adr %b", bus.state_o, bus.mem_read, bus.adr_src); end
        rst_n = 1'b0;
        #1;
        n_tests++; if (bus.mem_read !== 1'b0 || bus.adr_src !== 1'b0) begin n_fail++; $display("FAIL rst_abort_drop got rd %b adr %b exp 0/0", bus.mem_read, bus.adr_src); end
        for (int i = 0; i < 3; i++) begin
            tick();
            #4;
            if (bus.reg_write) seen_wb = 1'b1;
            n_tests++; if (bus.state_o !== S_FETCH || {bus.pc_write, bus.ir_write, bus.mem_read, bus.mem_write, bus.alu_src_b, bus.result_src} !== 8'b0) begin n_fail++; $display("FAIL rst_hold[%0d] got state %0d ctl %b", i, bus.state_o, {bus.pc_write, bus.ir_write, bus.mem_read, bus.mem_write, bus.alu_src_b, bus.result_src}); end
        end
        tick();
        rst_n = 1'b1;
        #4;
        if (bus.reg_write) seen_wb = 1'b1;
        tick();
        #4;
        n_tests++; if (bus.state_o !== S_FETCH || bus.mem_read !== 1'b1) begin n_fail++; $display("FAIL rst_release got state %0d rd %b exp 0/1", bus.state_o, bus.mem_read); end
        n_tests++; if (seen_wb !== 1'b0) begin n_fail++; $display("FAIL rst_no_wb got %b exp 0", seen_wb); end
        tick();
    endtask

    task automatic test_rtype();
        logic [3:0] es [4] = '{S_FETCH, S_DECODE, S_EXEC_R, S_ALU_WB};
        bus.opcode = OP_R;
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #4;
            n_tests++; if (bus.state_o !== es[i]) begin n_fail++; $display("FAIL r_state[%0d] got %0d exp %0d", i, bus.state_o, es[i]); end
            n_tests++; if (bus.reg_write !== (i == 3)) begin n_fail++; $display("FAIL r_regwrite[%0d] got %b exp %b", i, bus.reg_write, i == 3); end
            if (i == 0) begin
                n_tests++; if ({bus.ir_write, bus.pc_write, bus.alu_src_b, bus.result_src} !== 6'b11_10_10) begin n_fail++; $display("FAIL r_fetch_ctl got %b exp 111010", {bus.ir_write, bus.pc_write, bus.alu_src_b, bus.result_src}); end
            end
            if (i == 2) begin
                n_tests++; if ({bus.alu_op, bus.alu_src_a, bus.alu_src_b} !== 6'b10_10_00) begin n_fail++; $display("FAIL r_exec_ctl got %b exp 101000", {bus.alu_op, bus.alu_src_a, bus.alu_src_b}); end
            end
            tick();
        end
    endtask

    task automatic test_lw_wait();
        logic [3:0] es [8] = '{S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_READ, S_MEM_READ, S_MEM_READ, S_MEM_WB, S_FETCH};
        logic       rdy [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        bus.opcode = OP_LW;
        for (int i = 0; i < 8; i++) begin
            bus.mem_ready = rdy[i];
            #4;
            n_tests++; if (bus.state_o !== es[i]) begin n_fail++; $display("FAIL lw_state[%0d] got %0d exp %0d", i, bus.state_o, es[i]); end
            if (i == 2) begin
                n_tests++; if ({bus.imm_src, bus.alu_src_a, bus.alu_src_b} !== 7'b000_10_01) begin n_fail++; $display("FAIL lw_adr_ctl got %b exp 0001001", {bus.imm_src, bus.alu_src_a, bus.alu_src_b}); end
            end
            if (i >= 3 && i <= 5) begin
                n_tests++; if (bus.adr_src !== 1'b1 || bus.mem_read !== 1'b1) begin n_fail++; $display("FAIL lw_wait[%0d] got adr %b rd %b exp 1/1", i, bus.adr_src, bus.mem_read); end
            end
            if (i == 6) begin
                n_tests++; if (bus.result_src !== RES_DATA || bus.reg_write !== 1'b1) begin n_fail++; $display("FAIL lw_wb got res %b wr %b exp 01/1", bus.result_src, bus.reg_write); end
            end
            tick();
        end
    endtask

    task automatic test_branch();
        logic [2:0] f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        logic       z  [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic       l  [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic       ex [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int c = 0; c < 5; c++) begin
            bus.opcode = OP_B;
            bus.func3 = f3[c];
            bus.zero = z[c];
            bus.lt = l[c];
            bus.mem_ready = 1'b1;
            tick();
            #4;
            n_tests++; if (bus.state_o !== S_DECODE || bus.imm_src !== IMM_B) begin n_fail++; $display("FAIL br_decode[%0d] got state %0d imm %b", c, bus.state_o, bus.imm_src); end
            tick();
            #4;
            n_tests++; if (bus.state_o !== S_BRANCH || bus.pc_write !== ex[c] || bus.alu_op !== ALU_SUB) begin n_fail++; $display("FAIL br_taken[%0d] got state %0d pcw %b op %b exp pcw %b", c, bus.state_o, bus.pc_write, bus.alu_op, ex[c]); end
            if (c == 0) begin
                bus.zero = 1'b0;
                #1;
                n_tests++; if (bus.pc_write !== 1'b0) begin n_fail++; $display("FAIL br_comb got %b exp 0", bus.pc_write); end
            end
            tick();
        end
    endtask

    task automatic test_jalr();
`ifdef MC_CTRL_JALR_EN
        logic [3:0] es [5] = '{S_FETCH, S_DECODE, S_JALR, S_JAL, S_ALU_WB};
        logic       pw [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        bus.opcode = 7'b1100111;
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #4;
            n_tests++; if (bus.state_o !== es[i] || bus.pc_write !== pw[i]) begin n_fail++; $display("FAIL jalr[%0d] got state %0d pcw %b exp %0d/%b", i, bus.state_o, bus.pc_write, es[i], pw[i]); end
            tick();
        end
`else
        bus.opcode = 7'b1100111;
        bus.mem_ready = 1'b1;
        tick();
        #4;
        n_tests++; if (bus.state_o !== S_DECODE || {bus.pc_write, bus.reg_write, bus.mem_write, bus.ir_write} !== 4'b0) begin n_fail++; $display("FAIL jalr_off_decode got state %0d wr %b", bus.state_o, {bus.pc_write, bus.reg_write, bus.mem_write, bus.ir_write}); end
        tick();
        bus.mem_ready = 1'b0;
        #4;
        n_tests++; if (bus.state_o !== S_FETCH || {bus.pc_write, bus.reg_write, bus.mem_write, bus.ir_write} !== 4'b0) begin n_fail++; $display("FAIL jalr_off_fetch got state %0d wr %b", bus.state_o, {bus.pc_write, bus.reg_write, bus.mem_write, bus.ir_write}); end
        tick();
`endif
    endtask

    task automatic test_jal_lui_sw();
        bus.opcode = OP_JAL;
        bus.mem_ready = 1'b1;
        tick();
        #4;
        n_tests++; if (bus.imm_src !== IMM_J || bus.alu_src_a !== A_OLDPC) begin n_fail++; $display("FAIL jal_decode got imm %b a %b exp 011/01", bus.imm_src, bus.alu_src_a); end
        tick();
        #4;
        n_tests++; if (bus.state_o !== S_JAL || {bus.pc_write, bus.alu_src_a, bus.alu_src_b, bus.reg_write} !== 6'b1_01_10_0) begin n_fail++; $display("FAIL jal_exec got state %0d ctl %b", bus.state_o, {bus.pc_write, bus.alu_src_a, bus.alu_src_b, bus.reg_write}); end
        tick();
        #4;
        n_tests++; if (bus.state_o !== S_ALU_WB || bus.reg_write !== 1'b1) begin n_fail++; $display("FAIL jal_wb got state %0d wr %b", bus.state_o, bus.reg_write); end
        tick();
        bus.opcode = OP_LUI;
        tick();
        tick();
        #4;
        n_tests++; if (bus.state_o !== S_LUI || {bus.imm_src, bus.result_src, bus.reg_write} !== 6'b100_11_1) begin n_fail++; $display("FAIL lui got state %0d ctl %b", bus.state_o, {bus.imm_src, bus.result_src, bus.reg_write}); end
        tick();
        bus.opcode = OP_SW;
        tick();
        tick();
        #4;
        n_tests++; if (bus.state_o !== S_MEM_ADR || bus.imm_src !== IMM_S) begin n_fail++; $display("FAIL sw_adr got state %0d imm %b", bus.state_o, bus.imm_src); end
        tick();
        #4;
        n_tests++; if (bus.state_o !== S_MEM_WRITE || {bus.mem_write, bus.adr_src, bus.mem_read} !== 3'b110) begin n_fail++; $display("FAIL sw_write got state %0d ctl %b", bus.state_o, {bus.mem_write, bus.adr_src, bus.mem_read}); end
        tick();
        bus.mem_ready = 1'b0;
        #4;
        n_tests++; if (bus.state_o !== S_FETCH) begin n_fail++; $display("FAIL sw_done got state %0d exp 0", bus.state_o); end
        tick();
    endtask

    task automatic test_unknown();
        bus.opcode = 7'b0000000;
        bus.mem_ready = 1'b1;
        tick();
        #4;
        n_tests++; if (bus.state_o !== S_DECODE || {bus.pc_write, bus.reg_write, bus.mem_write, bus.ir_write} !== 4'b0) begin n_fail++; $display("FAIL unk_decode got state %0d wr %b", bus.state_o, {bus.pc_write, bus.reg_write, bus.mem_write, bus.ir_write}); end
        tick();
        bus.mem_ready = 1'b0;
        #4;
        n_tests++; if (bus.state_o !== S_FETCH || {bus.pc_write, bus.reg_write, bus.mem_write, bus.ir_write} !== 4'b0) begin n_fail++; $display("FAIL unk_fetch got state %0d wr %b", bus.state_o, {bus.pc_write, bus.reg_write, bus.mem_write, bus.ir_write}); end
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        bus.opcode = 7'b0;
        bus.func3 = 3'b0;
        bus.zero = 1'b0;
        bus.lt = 1'b0;
        bus.mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_rtype();
        test_lw_wait();
        test_branch();
        test_jalr();
        test_jal_lui_sw();
        test_unknown();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
